// File: rtl/eth_rx_frame_rd_ctrl_pkg.sv
// rtl/eth_rx_frame_rd_ctrl_pkg.sv - shared constants, state encoding and helpers for the RX frame read controller
// Contents: default parameters, header field positions, parser state enum, tail keep decode.
package eth_rx_pkg;

    localparam int           RD_LAT_DEF     = 1;
    localparam int           SKID_DEPTH_DEF = 4;
    localparam int           MAX_LEN_DEF    = 1518;
    localparam logic [3:0]   HDR_SYNC_DEF   = 4'hA;

    // Header word layout: [31:28] sync, [27:16] reserved, [15:0] length in bytes
    localparam int SYNC_MSB = 31;
    localparam int SYNC_LSB = 28;
    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 0;

    // Remaining-word counter holds (words left - 1), so 14 bits covers a full 16-bit length
    localparam int REM_W = 14;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Byte enables of the final word from the two low length bits
    function automatic logic [3:0] keep_decode(input logic [1:0] tail);
        case (tail)
            2'd1:    keep_decode = 4'h1;
            2'd2:    keep_decode = 4'h3;
            2'd3:    keep_decode = 4'h7;
            default: keep_decode = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/eth_rx_frame_rd_ctrl_if.sv
// rtl/eth_rx_frame_rd_ctrl_if.sv - frame output stream interface (valid/ready with data/keep/last)
// Signals: valid, ready, data[31:0] (byte 0 in [7:0]), keep[3:0], last.
// Modports: master drives the stream, slave accepts it.
interface eth_rx_frame_rd_ctrl_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/eth_rx_frame_rd_ctrl_prefetch.sv
// rtl/eth_rx_frame_rd_ctrl_prefetch.sv - buffer read credit logic, read-latency tracker and skid FIFO
// Ports: clk, rst (sync, active-high); buf_rd_en/buf_rd_data/buf_rd_empty to the RX buffer;
//        head/empty/pop towards the parser; inflight/occ expose the credit state.
module eth_rx_prefetch #(
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          buf_rd_en,
    input  logic [31:0]   buf_rd_data,
    input  logic          buf_rd_empty,
    output logic [31:0]   head,
    output logic          empty,
    input  logic          pop,
    output logic [CW-1:0] inflight,
    output logic [CW-1:0] occ
);

    logic [RD_LAT-1:0] vld_sr;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [31:0]       mem [DEPTH];
    logic [CW:0]       used;
    logic              ret;

    // A read returns RD_LAT cycles after its strobe; the MSB marks data on buf_rd_data now
    assign ret  = vld_sr[RD_LAT-1];
    assign occ  = wr_ptr - rd_ptr;
    assign used = {1'b0, inflight} + {1'b0, occ};

    // Credit counts outstanding reads as already occupying the skid, so a full skid never gets pushed
    assign buf_rd_en = !buf_rd_empty && (used < (CW+1)'(DEPTH));
    assign empty     = (occ == '0);
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr   <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            vld_sr   <= (vld_sr << 1) | RD_LAT'(buf_rd_en);
            inflight <= inflight + CW'(buf_rd_en) - CW'(ret);
            if (ret)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ret)
            mem[wr_ptr[AW-1:0]] <= buf_rd_data;
    end

endmodule

// File: rtl/eth_rx_frame_rd_ctrl.sv
// rtl/eth_rx_frame_rd_ctrl.sv - RX word buffer read sequencer: header parse, frame streaming, drop and stats
// Ports: clk, rst (sync, active-high); buf_rd_en/buf_rd_data/buf_rd_empty (RX buffer read side);
//        m (stream master: valid/ready/data/keep/last); frm_drop pulse; frm_cnt, drop_cnt saturating stats.
module eth_rx_frame_rd_ctrl
    import eth_rx_pkg::*;
#(
    parameter int         RD_LAT     = RD_LAT_DEF,
    parameter int         SKID_DEPTH = SKID_DEPTH_DEF,
    parameter int         MAX_LEN    = MAX_LEN_DEF,
    parameter logic [3:0] HDR_SYNC   = HDR_SYNC_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          buf_rd_en,
    input  logic [31:0]                   buf_rd_data,
    input  logic                          buf_rd_empty,
    eth_rx_frame_rd_ctrl_if.master        m,
    output logic                          frm_drop,
    output logic [15:0]                   frm_cnt,
    output logic [15:0]                   drop_cnt
);

    localparam int CW = $clog2(SKID_DEPTH) + 1;

    logic [31:0]      head;
    logic             sk_empty;
    logic             pop;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    occ;

    state_t           state, state_nxt;
    logic [REM_W-1:0] rem, rem_nxt;
    logic [3:0]       last_keep, keep_nxt;
    logic [15:0]      frm_cnt_nxt, drop_cnt_nxt;
    logic             drop_nxt;
    logic             valid;
    logic [15:0]      hdr_len;
    logic [3:0]       hdr_sync;
    logic [REM_W-1:0] nw_m1;

    eth_rx_prefetch #(
        .RD_LAT (RD_LAT),
        .DEPTH  (SKID_DEPTH)
    ) u_pf (
        .clk          (clk),
        .rst          (rst),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_data  (buf_rd_data),
        .buf_rd_empty (buf_rd_empty),
        .head         (head),
        .empty        (sk_empty),
        .pop          (pop),
        .inflight     (inflight),
        .occ          (occ)
    );

    assign hdr_sync = head[SYNC_MSB:SYNC_LSB];
    assign hdr_len  = head[LEN_MSB:LEN_LSB];
    // (len+3)>>2 words, stored minus one; only meaningful for len != 0
    assign nw_m1    = REM_W'((hdr_len - 16'd1) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HDR;
            rem       <= '0;
            last_keep <= 4'h0;
            frm_cnt   <= 16'h0;
            drop_cnt  <= 16'h0;
            frm_drop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            last_keep <= keep_nxt;
            frm_cnt   <= frm_cnt_nxt;
            drop_cnt  <= drop_cnt_nxt;
            frm_drop  <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        keep_nxt     = last_keep;
        frm_cnt_nxt  = frm_cnt;
        drop_cnt_nxt = drop_cnt;
        drop_nxt     = 1'b0;
        pop          = 1'b0;
        valid        = 1'b0;

        case (state)
            ST_HDR: begin
                if (!sk_empty) begin
                    pop = 1'b1;
                    if (hdr_sync != HDR_SYNC) begin
                        // Discard one word and try the next one as a header
                        drop_nxt = 1'b1;
                    end else if (hdr_len == 16'd0 || hdr_len > 16'(MAX_LEN)) begin
                        drop_nxt = 1'b1;
                        if (hdr_len != 16'd0) begin
                            state_nxt = ST_DROP;
                            rem_nxt   = nw_m1;
                        end
                    end else begin
                        state_nxt = ST_DATA;
                        rem_nxt   = nw_m1;
                        keep_nxt  = keep_decode(hdr_len[1:0]);
                    end
                end
            end
            ST_DATA: begin
                valid = !sk_empty;
                if (valid && m.ready) begin
                    pop = 1'b1;
                    if (rem == '0) begin
                        state_nxt = ST_HDR;
                        if (frm_cnt != 16'hFFFF)
                            frm_cnt_nxt = frm_cnt + 16'd1;
                    end else begin
                        rem_nxt = rem - 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!sk_empty) begin
                    pop = 1'b1;
                    if (rem == '0)
                        state_nxt = ST_HDR;
                    else
                        rem_nxt = rem - 1'b1;
                end
            end
            default: state_nxt = ST_HDR;
        endcase

        if (drop_nxt && drop_cnt != 16'hFFFF)
            drop_cnt_nxt = drop_cnt + 16'd1;
    end

    // Stream fields follow the skid head; zeroed while idle so nothing leaks between frames
    assign m.valid = valid;
    assign m.data  = valid ? head : 32'h0;
    assign m.last  = valid && (rem == '0);
    assign m.keep  = !valid ? 4'h0 : ((rem == '0) ? last_keep : 4'hF);

endmodule

// File: tb/tb_eth_rx_frame_rd_ctrl.sv
// tb/tb_eth_rx_frame_rd_ctrl.sv - directed self-checking bench for eth_rx_frame_rd_ctrl
module tb_eth_rx_frame_rd_ctrl;

    localparam int RDL   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_rd_en;
    logic [31:0] buf_rd_data;
    logic        buf_rd_empty;
    logic        frm_drop;
    logic [15:0] frm_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    eth_rx_frame_rd_ctrl_if m_if();

    eth_rx_frame_rd_ctrl #(
        .RD_LAT     (RDL),
        .SKID_DEPTH (DEPTH),
        .MAX_LEN    (1518),
        .HDR_SYNC   (4'hA)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_data  (buf_rd_data),
        .buf_rd_empty (buf_rd_empty),
        .m            (m_if.master),
        .frm_drop     (frm_drop),
        .frm_cnt      (frm_cnt),
        .drop_cnt     (drop_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // RX buffer model: unbounded word list, two-cycle read latency, flushed by rst
    logic [31:0] bufw [$];
    int          wr_n   = 0;
    int          rd_idx = 0;
    logic        gap    = 1'b0;
    logic [31:0] pipe0, pipe1;

    assign buf_rd_empty = gap || (rd_idx >= wr_n);
    assign buf_rd_data  = pipe1;

    always @(posedge clk) begin
        if (rst)
            rd_idx <= wr_n;
        else if (buf_rd_en)
            rd_idx <= rd_idx + 1;
        pipe0 <= (buf_rd_en && !rst && rd_idx < wr_n) ? bufw[rd_idx] : 32'hDEAD_BEEF;
        pipe1 <= pipe0;
    end

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q [$];
    int    seq = 0;

    task automatic push_word(input logic [31:0] w);
        bufw.push_back(w);
        wr_n++;
    endtask

    task automatic push_frame(input logic [3:0] sync, input int len, input int nw, input bit good);
        beat_t b;
        logic [31:0] w;
        push_word({sync, 12'h000, 16'(len)});
        for (int i = 0; i < nw; i++) begin
            w = good ? (32'h1000_0000 + 32'(seq)) : (32'hF000_0000 + 32'(seq));
            seq++;
            push_word(w);
            if (good) begin
                b.d = w;
                b.l = (i == nw - 1);
                if (i != nw - 1)       b.k = 4'hF;
                else if (len % 4 == 1) b.k = 4'h1;
                else if (len % 4 == 2) b.k = 4'h3;
                else if (len % 4 == 3) b.k = 4'h7;
                else                   b.k = 4'hF;
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: scoreboard, hold stability, credit bound, drop pulses
    int          cyc = 0;
    int          vcnt = 0;
    int          drop_seen = 0;
    int          beat_cnt = 0;
    int          t_first = 0;
    int          t_last = 0;
    logic [3:0]  last_keep_seen = 4'h0;
    logic        hold = 1'b0;
    logic [31:0] h_d;
    logic [3:0]  h_k;
    logic        h_l;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (m_if.valid) vcnt++;
            if (frm_drop)   drop_seen++;
            if (hold) begin
                chk("hold_valid", 32'(m_if.valid), 32'd1);
                chk("hold_data",  m_if.data, h_d);
                chk("hold_keep",  32'(m_if.keep), 32'(h_k));
                chk("hold_last",  32'(m_if.last), 32'(h_l));
            end
            chk("credit_bound", 32'((int'(u_dut.u_pf.inflight) + int'(u_dut.u_pf.occ)) <= DEPTH), 32'd1);
            if (buf_rd_en)
                chk("rd_while_empty", 32'(buf_rd_empty), 32'd0);
            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", m_if.data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_if.data, e.d);
                    chk("beat_keep", 32'(m_if.keep), 32'(e.k));
                    chk("beat_last", 32'(m_if.last), 32'(e.l));
                end
                if (beat_cnt == 0) t_first = cyc;
                t_last = cyc;
                beat_cnt++;
                if (m_if.last) last_keep_seen = m_if.keep;
            end
            hold = m_if.valid && !m_if.ready;
            h_d  = m_if.data;
            h_k  = m_if.keep;
            h_l  = m_if.last;
        end
    end

    bit rnd = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            m_if.ready = 1'($urandom_range(0, 1));
            gap        = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rd_idx < wr_n || !u_dut.u_pf.empty ||
                u_dut.u_pf.inflight != '0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int klen [3];
        logic [3:0] kexp [3];
        int total;
        int v0;
        int d0;
        int n;

        m_if.ready = 1'b1;
        gap = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",    32'(m_if.valid), 32'd0);
        chk("rst_last",     32'(m_if.last),  32'd0);
        chk("rst_keep",     32'(m_if.keep),  32'd0);
        chk("rst_drop",     32'(frm_drop),   32'd0);
        chk("rst_frm_cnt",  32'(frm_cnt),    32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt),   32'd0);
        chk("rst_rd_en",    32'(buf_rd_en),  32'd0);
        rst = 1'b0;
        tick();

        // 1: 64-byte frame, ready held high
        beat_cnt = 0;
        push_frame(4'hA, 64, 16, 1'b1);
        drain(500);
        chk("t1_beats",    32'(beat_cnt),       32'd16);
        chk("t1_frm_cnt",  32'(frm_cnt),        32'd1);
        chk("t1_drop_cnt", 32'(drop_cnt),       32'd0);
        chk("t1_keep",     32'(last_keep_seen), 32'hF);

        // 2: partial tail keep for 61/62/63 bytes
        klen[0] = 61; kexp[0] = 4'h1;
        klen[1] = 62; kexp[1] = 4'h3;
        klen[2] = 63; kexp[2] = 4'h7;
        for (int i = 0; i < 3; i++) begin
            beat_cnt = 0;
            push_frame(4'hA, klen[i], 16, 1'b1);
            drain(500);
            chk("t2_beats", 32'(beat_cnt),       32'd16);
            chk("t2_keep",  32'(last_keep_seen), 32'(kexp[i]));
        end
        chk("t2_frm_cnt", 32'(frm_cnt), 32'd4);

        // 2b: three back-to-back 64-byte frames, 48 beats plus two header cycles
        beat_cnt = 0;
        for (int i = 0; i < 3; i++) push_frame(4'hA, 64, 16, 1'b1);
        drain(500);
        chk("t2b_beats",   32'(beat_cnt),            32'd48);
        chk("t2b_span",    32'(t_last - t_first + 1), 32'd50);
        chk("t2b_frm_cnt", 32'(frm_cnt),             32'd7);

        // 3: bad sync word followed by a good 8-byte frame
        beat_cnt = 0;
        d0 = drop_seen;
        push_word(32'h5000_0040);
        push_frame(4'hA, 8, 2, 1'b1);
        drain(500);
        chk("t3_drop_pulses", 32'(drop_seen - d0), 32'd1);
        chk("t3_drop_cnt",    32'(drop_cnt),       32'd1);
        chk("t3_frm_cnt",     32'(frm_cnt),        32'd8);
        chk("t3_beats",       32'(beat_cnt),       32'd2);

        // 4: oversize frame (0x600 bytes, 384 words) silently discarded
        v0 = vcnt;
        d0 = drop_seen;
        push_frame(4'hA, 16'h0600, 384, 1'b0);
        drain(2000);
        chk("t4_no_valid",    32'(vcnt - v0),      32'd0);
        chk("t4_drop_pulses", 32'(drop_seen - d0), 32'd1);
        chk("t4_drop_cnt",    32'(drop_cnt),       32'd2);
        beat_cnt = 0;
        push_frame(4'hA, 20, 5, 1'b1);
        drain(500);
        chk("t4_beats",   32'(beat_cnt),       32'd5);
        chk("t4_keep",    32'(last_keep_seen), 32'hF);
        chk("t4_frm_cnt", 32'(frm_cnt),        32'd9);

        // 5: 100 random-length frames, random ready and buffer gaps
        beat_cnt = 0;
        total = 0;
        for (int i = 0; i < 100; i++) begin
            n = int'($urandom_range(1, 80));
            push_frame(4'hA, n, (n + 3) / 4, 1'b1);
            total += (n + 3) / 4;
        end
        rnd = 1'b1;
        drain(30000);
        rnd = 1'b0;
        m_if.ready = 1'b1;
        gap = 1'b0;
        tick();
        chk("t5_beats",    32'(beat_cnt), 32'(total));
        chk("t5_frm_cnt",  32'(frm_cnt),  32'd109);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd2);

        // 6: reset in the middle of a frame with reads in flight
        beat_cnt = 0;
        push_frame(4'hA, 64, 16, 1'b1);
        n = 0;
        while (beat_cnt < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_reach_mid", 32'(beat_cnt >= 5), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("t6_valid",    32'(m_if.valid), 32'd0);
        chk("t6_data",     m_if.data,       32'd0);
        chk("t6_keep",     32'(m_if.keep),  32'd0);
        chk("t6_last",     32'(m_if.last),  32'd0);
        chk("t6_drop",     32'(frm_drop),   32'd0);
        chk("t6_frm_cnt",  32'(frm_cnt),    32'd0);
        chk("t6_drop_cnt", 32'(drop_cnt),   32'd0);
        chk("t6_rd_en",    32'(buf_rd_en),  32'd0);
        rst = 1'b0;
        beat_cnt = 0;
        tick();
        push_frame(4'hA, 10, 3, 1'b1);
        drain(500);
        chk("t6_post_beats",    32'(beat_cnt),       32'd3);
        chk("t6_post_keep",     32'(last_keep_seen), 32'h3);
        chk("t6_post_frm_cnt",  32'(frm_cnt),        32'd1);
        chk("t6_post_drop_cnt", 32'(drop_cnt),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
